fdiv_front: RTL

Issue-and-reorder stage sitting directly upstream of the pipelined Newton-Raphson divider. Accepts operand pairs over a valid/ready handshake and screens IEEE-754 single-precision special cases and exponent over/underflow, resolving those locally. Only normal/normal pairs go to the divider as `div_a`/`div_b` with a one-cycle `div_start` pulse. Divider and bypass results merge in an in-order result buffer and leave on a valid/ready output with exception flags.

---
 rtl/fdiv_pkg.sv | 17 +
 rtl/fdiv_classify.sv | 47 ++++
 rtl/fdiv_front.sv | 106 ++++++++++
 3 files changed

// File: rtl/fdiv_pkg.sv
// fdiv_pkg: operand classes, canonical NaN and flag bit positions shared by the divider front end.
package fdiv_pkg;
    typedef enum logic [1:0] {NORM, ZERO, INF, NAN} cls_t;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    localparam int INVALID   = 3;
    localparam int DIVZERO   = 2;
    localparam int OVERFLOW  = 1;
    localparam int UNDERFLOW = 0;

    // Denormals flush to zero, so any exp=0 counts as ZERO.
    function automatic cls_t classify(input logic [31:0] x);
        return (x[30:23] == 8'hFF) ? ((x[22:0] != 23'd0) ? NAN : INF) :
               (x[30:23] == 8'h00) ? ZERO : NORM;
    endfunction
endpackage

// File: rtl/fdiv_classify.sv
// fdiv_classify: resolves special operands and exponent over/underflow;
// bypass=0 means the pair must go to the divider.
module fdiv_classify
    import fdiv_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        bypass,
    output logic [31:0] result,
    output logic [3:0]  flags
);
    cls_t ca, cb;
    logic s, inv;
    logic signed [9:0] e;

    assign ca  = classify(a);
    assign cb  = classify(b);
    assign s   = a[31] ^ b[31];
    assign inv = ca == NAN || cb == NAN || (ca == ZERO && cb == ZERO) || (ca == INF && cb == INF);
    // Quotient exponent, minus one when the dividend mantissa is the smaller.
    assign e   = 10'(a[30:23]) - 10'(b[30:23]) + 10'd127 - 10'(a[22:0] < b[22:0]);

    always_comb begin
        bypass = 1'b1;
        result = 32'd0;
        flags  = 4'd0;
        if (inv) begin
            result         = QNAN;
            flags[INVALID] = 1'b1;
        end else if (ca == NORM && cb == ZERO) begin
            result         = {s, 8'hFF, 23'd0};
            flags[DIVZERO] = 1'b1;
        end else if (ca == INF) begin
            result = {s, 8'hFF, 23'd0};
        end else if (ca == ZERO || cb == INF) begin
            result = {s, 31'd0};
        end else if (e >= 10'sd255) begin
            result          = {s, 8'hFF, 23'd0};
            flags[OVERFLOW] = 1'b1;
        end else if (e <= 10'sd0) begin
            result           = {s, 31'd0};
            flags[UNDERFLOW] = 1'b1;
        end else begin
            bypass = 1'b0;
        end
    end
endmodule

// File: rtl/fdiv_front.sv
// fdiv_front: screens operand pairs, issues normal/normal pairs to the divider and
// returns all results in acceptance order through a ring buffer.
module fdiv_front
    import fdiv_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DIV_II = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_start,
    input  logic [31:0] div_c,
    input  logic        div_done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_c,
    output logic [3:0]  out_flags
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = DIV_II > 1 ? $clog2(DIV_II) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [GW-1:0] GAP  = GW'(DIV_II - 1);

    logic          done  [DEPTH];
    logic [31:0]   res_c [DEPTH];
    logic [3:0]    res_f [DEPTH];
    logic [PW-1:0] pend  [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, pwr, prd;
    logic [CW-1:0] count, pcnt;
    logic [GW-1:0] gap;
    logic          bypass, accept, issue, pop, ret;
    logic [31:0]   result;
    logic [3:0]    flags;

    fdiv_classify u_cls (
        .a      (in_a),
        .b      (in_b),
        .bypass (bypass),
        .result (result),
        .flags  (flags)
    );

    assign in_ready  = count < FULL && gap == '0;
    assign accept    = in_valid && in_ready;
    assign issue     = accept && !bypass;
    assign out_valid = done[rd_ptr];
    assign out_c     = res_c[rd_ptr];
    assign out_flags = res_f[rd_ptr];
    assign pop       = out_valid && out_ready;
    // Returns with nothing pending (e.g. launched before a reset) are dropped.
    assign ret       = div_done && pcnt != '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                done[i]  <= 1'b0;
                res_c[i] <= 32'd0;
                res_f[i] <= 4'd0;
                pend[i]  <= '0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pwr       <= '0;
            prd       <= '0;
            count     <= '0;
            pcnt      <= '0;
            gap       <= '0;
            div_start <= 1'b0;
            div_a     <= 32'd0;
            div_b     <= 32'd0;
        end else begin
            div_start <= issue;
            gap       <= issue ? GAP : (gap != '0 ? gap - GW'(1) : gap);
            if (accept) begin
                done[wr_ptr]  <= bypass;
                res_c[wr_ptr] <= result;
                res_f[wr_ptr] <= flags;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (issue) begin
                div_a     <= in_a;
                div_b     <= in_b;
                pend[pwr] <= wr_ptr;
                pwr       <= pwr + PW'(1);
            end
            if (ret) begin
                done[pend[prd]]  <= 1'b1;
                res_c[pend[prd]] <= div_c;
                prd              <= prd + PW'(1);
            end
            if (pop) begin
                done[rd_ptr] <= 1'b0;
                rd_ptr       <= rd_ptr + PW'(1);
            end
            count <= count + CW'(accept) - CW'(pop);
            pcnt  <= pcnt + CW'(issue) - CW'(ret);
        end
    end
endmodule
